instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  IF stage front end: owns fetch PC, issues requests to instruction memory, buffers returned words in a small queue,
//  presents {PC+4, instruction} to the IF/ID pipeline register. Honours Stall_i/Flush_i from the hazard/branch logic;
//  on flush redirects to BranchTarget_i and discards stale in-flight data. Emits NOP bubbles when no word is ready.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch address after reset
//  FB_DEPTH   2              fetch buffer entries (power of 2, >=2)
// PORTS
//  clk_i           in   1   clock, all state on rising edge
//  rst_i           in   1   asynchronous, active-low reset
//  Stall_i         in   1   IF/ID holding; do not pop buffer
//  Flush_i         in   1   branch taken; redirect fetch
//  BranchTarget_i  in   32  redirect address, sampled when Flush_i=1
//  imem_req_o      out  1   fetch request valid
//  imem_addr_o     out  32  fetch address (word aligned)
//  imem_gnt_i      in   1   request accepted this cycle
//  imem_rvalid_i   in   1   read data valid (in order, >=1 cycle after gnt)
//  imem_rdata_i    in   32  instruction word
//  PC_o            out  32  PC+4 of presented instruction (0 when bubble)
//  instruction_o   out  32  presented instruction (32'b0 NOP when bubble)
//  valid_o         out  1   buffer head is a real instruction
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, buffer empty, state RUN, drop=0; imem_req_o=0, outputs PC_o=0, instruction_o=0, valid_o=0.
//  - FSM: RUN (no outstanding), WAIT (1 granted, awaiting rvalid), DROP (outstanding response to discard).
//    RUN->WAIT on req&gnt; WAIT->RUN on rvalid; WAIT->DROP on Flush_i; DROP->RUN on rvalid (data discarded).
//  - Max one outstanding request. imem_req_o=1 only in RUN, when count+0 < FB_DEPTH and Flush_i=0.
//  - imem_addr_o=fetch_pc; on req&gnt fetch_pc<=fetch_pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
//  - Request withdrawable before gnt; addr stable while req high and Flush_i=0.
//  - Push on rvalid in WAIT: entry {issued_pc+4, rdata}. Push never overflows (slot reserved at issue).
//  - Outputs combinational from buffer head; pop when Stall_i=0 and valid_o=1. Empty -> bubble (0,0,valid 0).
//  - Zero-latency bypass forbidden: word pushed in cycle N is visible on outputs in N+1.
//  - Flush_i=1: next edge fetch_pc<=BranchTarget_i, buffer cleared, outputs bubble that cycle; gnt in same cycle is
//    ignored (memory sees withdrawn req). Flush beats Stall and beats push/pop in the same cycle.
//  - rvalid in DROP or RUN: discarded, no push. Flush in DROP: stays DROP, new target latched.
//  - Stall_i with full buffer: no request issued; outputs hold head unchanged.
//  - Reset mid-WAIT: state cleared; a later stray rvalid in RUN is discarded.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds out ports perf_fetched_o[31:0] (pushes) and perf_dropped_o[31:0] (rvalids discarded
//  plus entries cleared by flush); both reset to 0, wrap at 2^32. Undefined: ports and counters absent, no other change.
// STRUCTURE
//  fetch_pkg: state encoding (RUN/WAIT/DROP), INSTR_NOP=32'b0, PC_STEP=4, entry width constant (64 bits).
//  Sub-module fetch_fifo: FB_DEPTH x 64 queue, push/pop/clear, full/empty/count; top holds FSM, PC, perf counters.
// TESTING
//  1 Reset, gnt=1 always, 1-cycle rvalid -> addrs 0,4,8...; PC_o=4 with word@0 two cycles after first gnt, valid_o=1.
//  2 Stall_i=1 for 5 cycles, buffer fills to 2 -> imem_req_o=0, outputs hold head; release -> pops in order.
//  3 Flush_i with BranchTarget_i=32'h100 in WAIT -> DROP; old rvalid discarded; next addr 0x100; PC_o=0x104.
//  4 Flush_i and Stall_i together with full buffer -> buffer empties, bubble (0,0,0), fetch resumes at target.
//  5 gnt held low 10 cycles -> req/addr stable, no outputs; rst_i low mid-WAIT -> all outputs 0 immediately.
//  6 FETCH_PERF_EN: 3 fetched, flush with 1 in flight + 2 buffered -> perf_fetched_o=3, perf_dropped_o=3.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its fetch buffer.
package fetch_pkg;

   typedef enum logic [1:0] {
      StRun  = 2'd0,
      StWait = 2'd1,
      StDrop = 2'd2
   } fetch_state_e;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
   localparam logic [31:0] PC_STEP   = 32'd4;
   localparam int unsigned ENTRY_W   = 64;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH x ENTRY_W circular queue with push/pop/clear and full/empty/count status.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic               clear,
   input  logic [ENTRY_W-1:0] wdata,
   output logic [ENTRY_W-1:0] rdata,
   output logic               full,
   output logic               empty,
   output logic [PTR_W:0]     count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
      end
   end

   // Storage needs no reset: entries are only read once count says they were written.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF-stage front end: fetch PC, single-outstanding imem handshake, buffered {PC+4, instr} to IF/ID.
// Defining FETCH_PERF_EN adds perf_fetched_o / perf_dropped_o event counters.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned FB_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        Stall_i,
   input  logic        Flush_i,
   input  logic [31:0] BranchTarget_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] PC_o,
   output logic [31:0] instruction_o,
   output logic        valid_o
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched_o,
   output logic [31:0] perf_dropped_o
`endif
);

   localparam int unsigned CNT_W = $clog2(FB_DEPTH) + 1;

   fetch_state_e       state;
   fetch_state_e       state_next;
   logic [31:0]        fetch_pc;
   logic [31:0]        fetch_pc_next;
   logic               active;
   logic               push;
   logic               pop;
   logic               discard;
   logic               full;
   logic               empty;
   logic [CNT_W-1:0]   count;
   logic [ENTRY_W-1:0] head_bits;
   fetch_entry_t       head;
   fetch_entry_t       push_entry;

   always_comb begin
      state_next = state;
      imem_req_o = 1'b0;
      push       = 1'b0;
      discard    = 1'b0;
      unique case (state)
         StRun: begin
            // active keeps the request low for the first cycle out of reset.
            imem_req_o = active & ~full & ~Flush_i;
            discard    = imem_rvalid_i;
            if (imem_req_o && imem_gnt_i) state_next = StWait;
         end
         StWait: begin
            if (imem_rvalid_i) begin
               state_next = StRun;
               push       = ~Flush_i;
               discard    = Flush_i;
            end else if (Flush_i) begin
               state_next = StDrop;
            end
         end
         StDrop: begin
            if (imem_rvalid_i) begin
               state_next = StRun;
               discard    = 1'b1;
            end
         end
         default: state_next = StRun;
      endcase
   end

   always_comb begin
      fetch_pc_next = fetch_pc;
      if (Flush_i) begin
         fetch_pc_next = BranchTarget_i;
      end else if (imem_req_o && imem_gnt_i) begin
         fetch_pc_next = fetch_pc + PC_STEP;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= StRun;
         fetch_pc <= RESET_PC;
         active   <= 1'b0;
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
         active   <= 1'b1;
      end
   end

   // fetch_pc already advanced at grant, so in WAIT it equals issued PC + 4.
   assign push_entry = '{pc: fetch_pc, instr: imem_rdata_i};
   assign head       = fetch_entry_t'(head_bits);

   assign imem_addr_o   = fetch_pc;
   assign valid_o       = ~empty & ~Flush_i;
   assign pop           = valid_o & ~Stall_i;
   assign PC_o          = valid_o ? head.pc : 32'h0;
   assign instruction_o = valid_o ? head.instr : INSTR_NOP;

   fetch_fifo #(
      .DEPTH (FB_DEPTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst_n (rst_i),
      .push  (push),
      .pop   (pop),
      .clear (Flush_i),
      .wdata (push_entry),
      .rdata (head_bits),
      .full  (full),
      .empty (empty),
      .count (count)
   );

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_dropped;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         perf_fetched <= '0;
         perf_dropped <= '0;
      end else begin
         perf_fetched <= perf_fetched + {31'b0, push};
         perf_dropped <= perf_dropped + {31'b0, discard} + (Flush_i ? 32'(count) : 32'd0);
      end
   end

   assign perf_fetched_o = perf_fetched;
   assign perf_dropped_o = perf_dropped;
`else
   logic unused_count;
   assign unused_count = ^count;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory responder, queued expectations, output monitor.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_i;
   logic        Stall_i;
   logic        Flush_i;
   logic [31:0] BranchTarget_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] PC_o;
   logic [31:0] instruction_o;
   logic        valid_o;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_o;
   logic [31:0] perf_dropped_o;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int grants_left = 0;
   int rv_delay = 0;
   int cyc = 0;
   int hs_count = 0;
   int first_hs_cyc = -1;
   int first_valid_cyc = -1;

   logic [31:0] addr_log [$];
   logic [63:0] sb [$];
   logic [63:0] mon_exp;

   logic        mem_pend = 1'b0;
   logic        mem_hs = 1'b0;
   logic [31:0] mem_addr = '0;
   int          mem_wait = 0;

   assign imem_gnt_i = (grants_left != 0);

   instr_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .FB_DEPTH (2)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .Stall_i        (Stall_i),
      .Flush_i        (Flush_i),
      .BranchTarget_i (BranchTarget_i),
      .imem_req_o     (imem_req_o),
      .imem_addr_o    (imem_addr_o),
      .imem_gnt_i     (imem_gnt_i),
      .imem_rvalid_i  (imem_rvalid_i),
      .imem_rdata_i   (imem_rdata_i),
      .PC_o           (PC_o),
      .instruction_o  (instruction_o),
      .valid_o        (valid_o)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched_o (perf_fetched_o),
      .perf_dropped_o (perf_dropped_o)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   // Memory: grant while budget remains, answer with word = C0DE_0000 | addr after rv_delay cycles.
   initial begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      forever begin
         @(negedge clk);
         mem_hs = rst_i && imem_req_o && imem_gnt_i;
         if (mem_hs) begin
            mem_pend = 1'b1;
            mem_addr = imem_addr_o;
            mem_wait = rv_delay;
            addr_log.push_back(imem_addr_o);
            hs_count++;
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
         end
         @(posedge clk);
         #1;
         if (mem_hs) grants_left--;
         if (mem_pend && mem_wait == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'hC0DE_0000 | mem_addr;
            mem_pend      = 1'b0;
         end else begin
            imem_rvalid_i = 1'b0;
            if (mem_pend) mem_wait--;
         end
      end
   end

   // Monitor: every popped output must match the head of the expectation queue.
   always @(negedge clk) begin
      if (rst_i && valid_o && !Stall_i) begin
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got pc %08h instr %08h, expected none", PC_o,
                     instruction_o);
         end else begin
            mon_exp = sb.pop_front();
            check("out_pc", PC_o, mon_exp[63:32]);
            check("out_instr", instruction_o, mon_exp[31:0]);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_drain(input int max);
      for (int i = 0; i < max && sb.size() != 0; i++) tick(1);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d entries outstanding, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic wait_hs(input int target, input int max);
      for (int i = 0; i < max && hs_count < target; i++) tick(1);
      n_cmp++;
      if (hs_count < target) begin
         n_bad++;
         $display("FAIL handshake_wait: got %0d grants, expected %0d", hs_count, target);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i          = 1'b0;
      Stall_i        = 1'b0;
      Flush_i        = 1'b0;
      BranchTarget_i = '0;
      tick(3);
      #1;
      check("rst_req", imem_req_o, 0);
      check("rst_pc", PC_o, 0);
      check("rst_instr", instruction_o, 0);
      check("rst_valid", valid_o, 0);

      // Streaming fetch, gnt always available for three requests.
      sb.push_back({32'h0000_0004, 32'hC0DE_0000});
      sb.push_back({32'h0000_0008, 32'hC0DE_0004});
      sb.push_back({32'h0000_000C, 32'hC0DE_0008});
      grants_left = 3;
      rst_i = 1'b1;
      wait_drain(40);
      check("first_latency", first_valid_cyc - first_hs_cyc, 2);
      check("addr0", addr_log[0], 32'h0);
      check("addr1", addr_log[1], 32'h4);
      check("addr2", addr_log[2], 32'h8);

      // Stall until the buffer is full, then release.
      Stall_i = 1'b1;
      grants_left = 3;
      tick(5);
      #1;
      check("full_req", imem_req_o, 0);
      check("full_valid", valid_o, 1);
      check("full_pc", PC_o, 32'h10);
      check("full_instr", instruction_o, 32'hC0DE_000C);
      tick(2);
      #1;
      check("hold_pc", PC_o, 32'h10);
      check("hold_req", imem_req_o, 0);
      sb.push_back({32'h0000_0010, 32'hC0DE_000C});
      sb.push_back({32'h0000_0014, 32'hC0DE_0010});
      sb.push_back({32'h0000_0018, 32'hC0DE_0014});
      Stall_i = 1'b0;
      wait_drain(40);
      check("stall_hs", hs_count, 6);

      // Flush while waiting for a response: stale word discarded, refetch at target.
      grants_left = 1;
      rv_delay = 3;
      wait_hs(7, 10);
      Flush_i = 1'b1;
      BranchTarget_i = 32'h100;
      rv_delay = 0;
      #1;
      check("flush_req", imem_req_o, 0);
      check("flush_valid", valid_o, 0);
      tick(1);
      Flush_i = 1'b0;
      grants_left = 1;
      #1;
      check("drop_req", imem_req_o, 0);
      sb.push_back({32'h0000_0104, 32'hC0DE_0100});
      wait_drain(40);
      check("redirect_addr", addr_log[7], 32'h100);

      // Flush together with Stall on a full buffer; gnt offered during flush is ignored.
      Stall_i = 1'b1;
      grants_left = 2;
      tick(6);
      #1;
      check("f4_valid", valid_o, 1);
      check("f4_pc", PC_o, 32'h108);
      grants_left = 5;
      Flush_i = 1'b1;
      BranchTarget_i = 32'h200;
      #1;
      check("fs_valid", valid_o, 0);
      check("fs_pc", PC_o, 0);
      check("fs_instr", instruction_o, 0);
      check("fs_req", imem_req_o, 0);
      tick(1);
      Flush_i = 1'b0;
      Stall_i = 1'b0;
      grants_left = 1;
      sb.push_back({32'h0000_0204, 32'hC0DE_0200});
      #1;
      check("fs_cleared", valid_o, 0);
      check("fs_addr", imem_addr_o, 32'h200);
      check("fs_req_resume", imem_req_o, 1);
      wait_drain(40);
      check("fs_hs", hs_count, 11);

      // Grant withheld: request and address hold steady.
      Stall_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         #1;
         check("nogrant_req", imem_req_o, 1);
         check("nogrant_addr", imem_addr_o, 32'h204);
      end
      grants_left = 1;
      rv_delay = 0;
      tick(4);
      #1;
      check("pre_rst_valid", valid_o, 1);
      check("pre_rst_pc", PC_o, 32'h208);
      check("pre_rst_instr", instruction_o, 32'hC0DE_0204);
      rv_delay = 4;
      grants_left = 1;
      tick(1);
      rst_i = 1'b0;
      #1;
      check("midrst_req", imem_req_o, 0);
      check("midrst_valid", valid_o, 0);
      check("midrst_pc", PC_o, 0);
      check("midrst_instr", instruction_o, 0);
      tick(2);
      rst_i = 1'b1;
      Stall_i = 1'b0;
      tick(6);
      #1;
      check("post_rst_req", imem_req_o, 1);
      check("post_rst_addr", imem_addr_o, 32'h0);
      check("post_rst_valid", valid_o, 0);
      sb.push_back({32'h0000_0004, 32'hC0DE_0000});
      grants_left = 1;
      wait_drain(40);
      check("post_rst_hs", hs_count, 14);

`ifdef FETCH_PERF_EN
      // Counters since the last reset: word@0 fetched, stray rvalid dropped.
      sb.push_back({32'h0000_0008, 32'hC0DE_0004});
      grants_left = 1;
      wait_drain(40);
      Stall_i = 1'b1;
      grants_left = 1;
      rv_delay = 0;
      tick(4);
      grants_left = 1;
      rv_delay = 5;
      wait_hs(17, 10);
      Flush_i = 1'b1;
      BranchTarget_i = 32'h300;
      tick(1);
      Flush_i = 1'b0;
      tick(8);
      #1;
      check("perf_fetched", perf_fetched_o, 3);
      check("perf_dropped", perf_dropped_o, 3);
      Stall_i = 1'b0;
`endif

      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
